cpu_state_dumper: RTL and testbench
===================================

# cpu_state_dumper

Debug block beside Simple_Single_CPU that streams a snapshot of the register file and data memory over a valid/ready channel, replacing per-cycle `$display` dumps with synthesizable hardware. Triggered manually or periodically; walks REG_N registers then MEM_N memory words through combinational read ports and emits one tagged, indexed word per beat. Optional `freeze_o` lets the CPU stall for a coherent snapshot.

## Interface
- DATA_W, 32, word width of registers, memory and PC
- REG_N, 32, registers dumped (indices 0..REG_N-1)
- MEM_N, 32, memory words dumped (word indices 0..MEM_N-1)
- PERIOD, 0, auto-trigger interval in cycles; 0 = manual trigger only
- IDX_W, derived, $clog2(max(REG_N,MEM_N)), minimum 1
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- trig_i  in  1  dump request, single-cycle pulse
- pc_i  in  DATA_W  current CPU PC
- rf_addr_o  out  IDX_W  register read address
- rf_data_i  in  DATA_W  register data, combinational from rf_addr_o
- mem_addr_o  out  IDX_W  memory word address
- mem_data_i  in  DATA_W  memory data, combinational from mem_addr_o
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  sink ready
- out_data_o  out  DATA_W  beat payload
- out_tag_o  out  2  source: 0 PC, 1 register, 2 memory
- out_idx_o  out  IDX_W  index within source
- out_last_o  out  1  final beat of dump
- busy_o  out  1  dump in progress
- freeze_o  out  1  equals busy_o; CPU stall request
- overrun_o  out  1  sticky: trigger dropped
- dump_cnt_o  out  16  completed dumps, wraps at 2^16

## Operation
- States: IDLE, HDR, REGS, MEM. IDLE --trig--> HDR (macro on) or REGS; HDR -> REGS after accept; REGS -> MEM after index REG_N-1 accepted; MEM -> IDLE after index MEM_N-1 accepted.
- Trigger = trig_i OR period tick. Period counter counts 0..PERIOD-1 from reset, ticks at PERIOD-1, runs regardless of busy.
- Trigger while busy: latched into one-deep pending flag; trigger with pending already set is dropped and sets overrun_o (cleared only by reset).
- Output register: beat loaded when out_valid_o=0 or (out_valid_o & out_ready_i); held stable otherwise. Addresses advance only on load.
- Data sampled at load cycle; values not frozen unless CPU honours freeze_o.
- out_last_o on MEM index MEM_N-1 beat. On its acceptance dump_cnt_o increments.
- Reset (any time, mid-dump included): state IDLE, all outputs 0, pending, counters, overrun cleared.

## Timing
- Trigger in cycle t (IDLE): busy_o and first beat valid at t+1.
- Ready held high: one beat per cycle, no bubbles; dump length REG_N+MEM_N (+1 with header) cycles.
- busy_o falls the cycle after last acceptance. Pending dump then starts: one IDLE cycle, first beat two cycles after last acceptance.
- Trigger coincident with last acceptance: treated as pending.
- Index wrap: address counters reset to 0 on state change; never exceed N-1.

## Configuration
- DUMP_PC_HEADER_EN defined: each dump starts with one beat, tag 0, idx 0, data = pc_i sampled at load. Not defined: HDR state absent, dump starts with register 0; pc_i unused.

## Structure
- Package cpu_dbg_pkg: tag constants (TAG_PC=0, TAG_REG=1, TAG_MEM=2), state encoding, dump_cnt width 16.
- Sub-module dump_trig_gen: PERIOD counter plus pending/overrun logic, outputs start pulse.

## Test plan
- REG_N=4, MEM_N=4, macro off, reg i = 10+i, mem i = 100+i, ready high, trig at t=5 -> beats t=6..13: (1,0,10)..(1,3,13),(2,0,100)..(2,3,103), last at t=13, dump_cnt_o=1 at t=14.
- Same, ready low on cycles 7-9 -> beat (1,1,11) held stable through 9, no beat lost or duplicated, last beat at t=16.
- Macro on, pc_i=0x40 -> first beat tag 0 data 0x40, 9 beats total.
- Trig at t=5, t=7, t=8 -> second dump starts two cycles after first last-accept, overrun_o=1 from t=9, dump_cnt_o=2 at end.
- PERIOD=20 -> dumps start cycles 20, 40; reset asserted mid-dump at cycle 25 -> outputs 0 immediately, counter restarts, next dump at 20 cycles after reset release.

Source files
------------

// File: rtl/cpu_state_dumper_pkg.sv
// Shared constants for the CPU state dumper: beat tags, FSM encoding, counter width.
// The optional PC header beat is controlled by DUMP_PC_HEADER_EN.
package cpu_dbg_pkg;

    localparam logic [1:0] TAG_PC  = 2'd0;
    localparam logic [1:0] TAG_REG = 2'd1;
    localparam logic [1:0] TAG_MEM = 2'd2;

    localparam int DUMP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_REGS = 2'd2,
        ST_MEM  = 2'd3
    } dump_state_e;

    // Index width covering both address spaces, never narrower than one bit.
    function automatic int idx_width(input int reg_n, input int mem_n);
        int m;
        m = (reg_n > mem_n) ? reg_n : mem_n;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cpu_state_dumper_if.sv
// Valid/ready beat channel carrying one tagged, indexed snapshot word per beat.
interface cpu_state_dumper_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [1:0]        tag;
    logic [IDX_W-1:0]  idx;
    logic              last;

    modport master (output valid, data, tag, idx, last, input ready);
    modport slave  (input valid, data, tag, idx, last, output ready);
endinterface

// File: rtl/cpu_state_dumper_trig_gen.sv
// Dump trigger source: manual pulse OR periodic tick, with a one-deep pending
// slot for requests arriving while a dump runs and a sticky overrun flag.
module dump_trig_gen #(
    parameter int PERIOD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    input  logic idle,
    output logic start,
    output logic overrun
);
    logic tick;
    logic req;
    logic pending;

    generate
        if (PERIOD > 0) begin : g_period
            localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
            logic [CW-1:0] cnt;

            // Free-running; keeps counting while a dump is in progress.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)              cnt <= '0;
                else if (cnt == LAST) cnt <= '0;
                else                  cnt <= cnt + 1'b1;
            end

            assign tick = (cnt == LAST);
        end else begin : g_manual
            assign tick = 1'b0;
        end
    endgenerate

    assign req   = trig | tick;
    assign start = idle & (req | pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (idle) begin
            // A start consumes one request; a second one in the same cycle waits.
            pending <= pending & req;
        end else if (req) begin
            pending <= 1'b1;
            if (pending) overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// Streams a register-file and data-memory snapshot as valid/ready beats.
// Define DUMP_PC_HEADER_EN to prefix every dump with one PC beat (tag 0).
module cpu_state_dumper
    import cpu_dbg_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  REG_N  = 32,
    parameter int  MEM_N  = 32,
    parameter int  PERIOD = 0,
    localparam int IDX_W  = idx_width(REG_N, MEM_N)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trig_i,
    input  logic [DATA_W-1:0]     pc_i,
    output logic [IDX_W-1:0]      rf_addr_o,
    input  logic [DATA_W-1:0]     rf_data_i,
    output logic [IDX_W-1:0]      mem_addr_o,
    input  logic [DATA_W-1:0]     mem_data_i,
    cpu_state_dumper_if.master    out,
    output logic                  busy_o,
    output logic                  freeze_o,
    output logic                  overrun_o,
    output logic [DUMP_CNT_W-1:0] dump_cnt_o
);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_N - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_N - 1);

    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] a,
                                             input logic [IDX_W-1:0] last);
        return (a == last) ? '0 : a + 1'b1;
    endfunction

    dump_state_e state;
    logic        start;
    logic        load;

    dump_trig_gen #(.PERIOD(PERIOD)) u_trig (
        .clk     (clk_i),
        .rst     (rst_i),
        .trig    (trig_i),
        .idle    (state == ST_IDLE),
        .start   (start),
        .overrun (overrun_o)
    );

    assign load     = !out.valid || out.ready;
    assign busy_o   = (state != ST_IDLE);
    assign freeze_o = busy_o;

`ifndef DUMP_PC_HEADER_EN
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    // state names the source of the beat currently held in the output register;
    // rf_addr_o / mem_addr_o always point at the next word to be loaded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            out.valid  <= 1'b0;
            out.data   <= '0;
            out.tag    <= '0;
            out.idx    <= '0;
            out.last   <= 1'b0;
            rf_addr_o  <= '0;
            mem_addr_o <= '0;
            dump_cnt_o <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    out.valid <= 1'b1;
                    out.idx   <= '0;
`ifdef DUMP_PC_HEADER_EN
                    state     <= ST_HDR;
                    out.tag   <= TAG_PC;
                    out.data  <= pc_i;
`else
                    state     <= ST_REGS;
                    out.tag   <= TAG_REG;
                    out.data  <= rf_data_i;
                    rf_addr_o <= nxt(rf_addr_o, REG_LAST);
`endif
                end
`ifdef DUMP_PC_HEADER_EN
                ST_HDR: if (load) begin
                    state     <= ST_REGS;
                    out.tag   <= TAG_REG;
                    out.idx   <= rf_addr_o;
                    out.data  <= rf_data_i;
                    rf_addr_o <= nxt(rf_addr_o, REG_LAST);
                end
`endif
                ST_REGS: if (load) begin
                    if (out.idx == REG_LAST) begin
                        state      <= ST_MEM;
                        out.tag    <= TAG_MEM;
                        out.idx    <= mem_addr_o;
                        out.data   <= mem_data_i;
                        out.last   <= (mem_addr_o == MEM_LAST);
                        mem_addr_o <= nxt(mem_addr_o, MEM_LAST);
                    end else begin
                        out.idx    <= rf_addr_o;
                        out.data   <= rf_data_i;
                        rf_addr_o  <= nxt(rf_addr_o, REG_LAST);
                    end
                end
                ST_MEM: if (load) begin
                    if (out.last) begin
                        state      <= ST_IDLE;
                        out.valid  <= 1'b0;
                        out.last   <= 1'b0;
                        out.data   <= '0;
                        out.tag    <= '0;
                        out.idx    <= '0;
                        dump_cnt_o <= dump_cnt_o + 1'b1;
                    end else begin
                        out.idx    <= mem_addr_o;
                        out.data   <= mem_data_i;
                        out.last   <= (mem_addr_o == MEM_LAST);
                        mem_addr_o <= nxt(mem_addr_o, MEM_LAST);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out.valid <= 1'b0;
                    out.last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench: manual dumps (free-running and stalled sink), pending/overrun,
// mid-dump reset, and a second instance exercising the periodic trigger.
module tb_cpu_state_dumper;
    localparam int REG_N = 4;
    localparam int MEM_N = 4;
    localparam int IDX_W = 2;
`ifdef DUMP_PC_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int L = REG_N + MEM_N + HDR;
    localparam logic [31:0] PC = 32'h40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_p, trig;
    logic [31:0] pc = PC;
    int gcyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    // main instance, manual trigger
    cpu_state_dumper_if #(.DATA_W(32), .IDX_W(IDX_W)) dif ();
    logic [IDX_W-1:0] rf_addr, mem_addr;
    logic [31:0] rf_data, mem_data;
    logic busy, freeze, overrun;
    logic [15:0] dump_cnt;
    assign rf_data  = 32'd10 + 32'(rf_addr);
    assign mem_data = 32'd100 + 32'(mem_addr);

    cpu_state_dumper #(.DATA_W(32), .REG_N(REG_N), .MEM_N(MEM_N), .PERIOD(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .trig_i(trig), .pc_i(pc),
        .rf_addr_o(rf_addr), .rf_data_i(rf_data),
        .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .out(dif), .busy_o(busy), .freeze_o(freeze),
        .overrun_o(overrun), .dump_cnt_o(dump_cnt)
    );

    // periodic instance
    cpu_state_dumper_if #(.DATA_W(32), .IDX_W(IDX_W)) pif ();
    logic [IDX_W-1:0] p_rf_addr, p_mem_addr;
    logic [31:0] p_rf_data, p_mem_data;
    logic p_busy, p_freeze, p_overrun;
    logic [15:0] p_cnt;
    logic p_trig = 1'b0;
    assign p_rf_data  = 32'd10 + 32'(p_rf_addr);
    assign p_mem_data = 32'd100 + 32'(p_mem_addr);

    cpu_state_dumper #(.DATA_W(32), .REG_N(REG_N), .MEM_N(MEM_N), .PERIOD(20)) u_per (
        .clk_i(clk), .rst_i(rst_p), .trig_i(p_trig), .pc_i(pc),
        .rf_addr_o(p_rf_addr), .rf_data_i(p_rf_data),
        .mem_addr_o(p_mem_addr), .mem_data_i(p_mem_data),
        .out(pif), .busy_o(p_busy), .freeze_o(p_freeze),
        .overrun_o(p_overrun), .dump_cnt_o(p_cnt)
    );

    typedef struct {
        logic [1:0]       tag;
        logic [IDX_W-1:0] idx;
        logic [31:0]      data;
        logic             last;
        int               cyc;
    } beat_t;
    beat_t q[$];
    beat_t b;

    always @(negedge clk) begin
        if (!rst && dif.valid && dif.ready) begin
            b.tag = dif.tag; b.idx = dif.idx; b.data = dif.data;
            b.last = dif.last; b.cyc = gcyc;
            q.push_back(b);
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_beat(input int k, output logic [1:0] t, output int i,
                            output logic [31:0] d, output logic l);
        int r;
        r = k - HDR;
        l = (k == L - 1);
        if (HDR == 1 && k == 0) begin
            t = 2'd0; i = 0; d = PC;
        end else if (r < REG_N) begin
            t = 2'd1; i = r; d = 32'(10 + r);
        end else begin
            t = 2'd2; i = r - REG_N; d = 32'(100 + i);
        end
    endtask

    task automatic check_dump(input string p, input int q0, input int c0, input int stall);
        logic [1:0] et; int ei; logic [31:0] ed; logic el; int ec;
        for (int k = 0; k < L; k++) begin
            exp_beat(k, et, ei, ed, el);
            ec = c0 + k + ((k >= 1) ? stall : 0);
            if (q0 + k < q.size()) begin
                chk($sformatf("%s.b%0d.cyc", p, k),  q[q0+k].cyc,  ec);
                chk($sformatf("%s.b%0d.tag", p, k),  q[q0+k].tag,  et);
                chk($sformatf("%s.b%0d.idx", p, k),  q[q0+k].idx,  ei);
                chk($sformatf("%s.b%0d.data", p, k), q[q0+k].data, ed);
                chk($sformatf("%s.b%0d.last", p, k), q[q0+k].last, el);
            end else begin
                chk($sformatf("%s.b%0d.present", p, k), q.size(), q0 + k + 1);
            end
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 100) begin tick(); n++; end
        chk({nm, ".idle"}, busy, 0);
    endtask

    task automatic wait_pvalid(input string nm, output int c);
        int n = 0;
        while (!pif.valid && n < 100) begin tick(); n++; end
        chk({nm, ".valid"}, pif.valid, 1);
        c = gcyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int T, R, c;
        logic [1:0] et; int ei; logic [31:0] ed; logic el;
        rst = 1'b0; rst_p = 1'b0; trig = 1'b0;
        dif.ready = 1'b1; pif.ready = 1'b1;
        #2; rst = 1'b1; rst_p = 1'b1;
        tick(); tick();
        chk("rst.valid", dif.valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.freeze", freeze, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.cnt", dump_cnt, 0);
        chk("rst.rf_addr", rf_addr, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.last", dif.last, 0);
        rst = 1'b0;
        tick(); tick();

        // A: ready held high, no bubbles
        q.delete();
        tick(); T = gcyc; trig = 1'b1;
        tick(); trig = 1'b0;
        chk("A.busy", busy, 1);
        chk("A.freeze", freeze, 1);
        chk("A.valid", dif.valid, 1);
        wait_idle("A");
        chk("A.end_cyc", gcyc, T + L + 1);
        chk("A.cnt", dump_cnt, 1);
        chk("A.nbeats", q.size(), L);
        check_dump("A", 0, T + 1, 0);

        // B: sink stalls for three cycles while beat 1 is presented
        q.delete();
        tick(); T = gcyc; trig = 1'b1;
        tick(); trig = 1'b0;
        exp_beat(1, et, ei, ed, el);
        for (int s = 0; s < 3; s++) begin
            tick(); dif.ready = 1'b0;
            chk($sformatf("B.hold%0d.valid", s), dif.valid, 1);
            chk($sformatf("B.hold%0d.tag", s), dif.tag, et);
            chk($sformatf("B.hold%0d.idx", s), dif.idx, ei);
            chk($sformatf("B.hold%0d.data", s), dif.data, ed);
        end
        tick(); dif.ready = 1'b1;
        wait_idle("B");
        chk("B.end_cyc", gcyc, T + L + 4);
        chk("B.cnt", dump_cnt, 2);
        chk("B.nbeats", q.size(), L);
        check_dump("B", 0, T + 1, 3);

        // C: triggers at T, T+2, T+3 -> one pending, one dropped
        q.delete();
        tick(); T = gcyc; trig = 1'b1;
        tick(); trig = 1'b0;
        tick(); trig = 1'b1;
        tick();
        chk("C.overrun_pre", overrun, 0);
        tick(); trig = 1'b0;
        chk("C.overrun", overrun, 1);
        wait_idle("C1");
        chk("C1.end_cyc", gcyc, T + L + 1);
        tick();
        chk("C2.busy", busy, 1);
        wait_idle("C2");
        chk("C2.end_cyc", gcyc, T + 2 * L + 2);
        chk("C.cnt", dump_cnt, 4);
        chk("C.overrun_sticky", overrun, 1);
        chk("C.nbeats", q.size(), 2 * L);
        check_dump("C1", 0, T + 1, 0);
        check_dump("C2", L, T + L + 2, 0);

        // E: reset mid-dump clears everything at once
        tick(); trig = 1'b1;
        tick(); trig = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        chk("E.valid", dif.valid, 0);
        chk("E.busy", busy, 0);
        chk("E.overrun", overrun, 0);
        chk("E.cnt", dump_cnt, 0);
        chk("E.rf_addr", rf_addr, 0);
        chk("E.data", dif.data, 0);
        tick(); rst = 1'b0;
        tick(); tick(); tick();
        chk("E.stay_idle", busy, 0);

        // D: periodic trigger, PERIOD=20
        tick(); rst_p = 1'b0; R = gcyc;
        wait_pvalid("D1", c);
        chk("D1.cyc", c, R + 20);
        chk("D1.data", pif.data, (HDR == 1) ? PC : 32'd10);
        while (p_busy && gcyc < R + 60) tick();
        wait_pvalid("D2", c);
        chk("D2.cyc", c, R + 40);
        chk("D2.cnt", p_cnt, 1);
        repeat (5) tick();
        rst_p = 1'b1; #1;
        chk("D.rst.valid", pif.valid, 0);
        chk("D.rst.busy", p_busy, 0);
        chk("D.rst.cnt", p_cnt, 0);
        chk("D.rst.rf_addr", p_rf_addr, 0);
        tick(); rst_p = 1'b0; R = gcyc;
        wait_pvalid("D3", c);
        chk("D3.cyc", c, R + 20);
        chk("D.overrun", p_overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
